// File: rtl/match_controller.sv
// Match-level sequencer for pong: gates paddle/ball motion, re-serves after a miss,
// keeps both scores and stops the match when either side reaches WIN_SCORE.
module match_controller #(
  parameter int X_POS_W            = 10,
  parameter int SCREEN_H_RES       = 640,
  parameter int SCREEN_BORDER      = 10,
  parameter int SCORE_W            = 4,
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               new_frame_i,
  input  logic               start_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic               run_o,
  output logic               serve_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] enemy_score_o,
  output logic               game_over_o,
  output logic               winner_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [CNT_W-1:0]   LAST_FRAME = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [CNT_W-1:0]   frame_cnt;
  logic               start_q;
  logic               start_edge;
  logic               miss_right;
  logic               miss_left;
  logic [SCORE_W-1:0] enemy_next;
  logic [SCORE_W-1:0] player_next;

  assign start_edge  = start_i & ~start_q;
  assign miss_right  = ball_x_i > X_POS_W'(SCREEN_H_RES);
  assign miss_left   = ball_x_i < X_POS_W'(SCREEN_BORDER);
  assign enemy_next  = enemy_score_o + SCORE_W'(1);
  assign player_next = player_score_o + SCORE_W'(1);
  assign state_o     = state;

  // start_q resets high so a key held through reset does not count as a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      start_q        <= 1'b1;
      run_o          <= 1'b0;
      serve_o        <= 1'b0;
      serve_dir_o    <= 1'b0;
      player_score_o <= '0;
      enemy_score_o  <= '0;
      game_over_o    <= 1'b0;
      winner_o       <= 1'b0;
    end else begin
      start_q <= start_i;
      serve_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            player_score_o <= '0;
            enemy_score_o  <= '0;
            serve_dir_o    <= 1'b0;
            serve_o        <= 1'b1;
            frame_cnt      <= '0;
            state          <= SERVE;
          end
        end
        SERVE: begin
          if (new_frame_i) begin
            if (frame_cnt == LAST_FRAME) begin
              run_o <= 1'b1;
              state <= PLAY;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        // A miss takes priority over a simultaneous start press.
        PLAY: begin
          if (new_frame_i && (miss_right || miss_left)) begin
            run_o <= 1'b0;
            if (miss_right) begin
              enemy_score_o <= enemy_next;
              serve_dir_o   <= 1'b1;
              if (enemy_next == WIN) begin
                game_over_o <= 1'b1;
                winner_o    <= 1'b1;
                state       <= OVER;
              end else begin
                state <= POINT;
              end
            end else begin
              player_score_o <= player_next;
              serve_dir_o    <= 1'b0;
              if (player_next == WIN) begin
                game_over_o <= 1'b1;
                winner_o    <= 1'b0;
                state       <= OVER;
              end else begin
                state <= POINT;
              end
            end
          end else if (start_edge) begin
            run_o <= 1'b0;
            state <= PAUSE;
          end
        end
        POINT: begin
          serve_o   <= 1'b1;
          frame_cnt <= '0;
          state     <= SERVE;
        end
        PAUSE: begin
          if (start_edge) begin
            run_o <= 1'b1;
            state <= PLAY;
          end
        end
        OVER: begin
          if (start_edge) begin
            player_score_o <= '0;
            enemy_score_o  <= '0;
            game_over_o    <= 1'b0;
            winner_o       <= 1'b0;
            serve_dir_o    <= 1'b0;
            serve_o        <= 1'b1;
            frame_cnt      <= '0;
            state          <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a short serve delay and a 2-point match.
module tb_match_controller;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       new_frame_i = 1'b0;
  logic       start_i = 1'b1;
  logic [9:0] ball_x_i = 10'd320;
  logic       run_o;
  logic       serve_o;
  logic       serve_dir_o;
  logic [3:0] player_score_o;
  logic [3:0] enemy_score_o;
  logic       game_over_o;
  logic       winner_o;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  match_controller #(
    .X_POS_W(10), .SCREEN_H_RES(640), .SCREEN_BORDER(10),
    .SCORE_W(4), .WIN_SCORE(2), .SERVE_DELAY_FRAMES(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .new_frame_i(new_frame_i), .start_i(start_i),
    .ball_x_i(ball_x_i), .run_o(run_o), .serve_o(serve_o), .serve_dir_o(serve_dir_o),
    .player_score_o(player_score_o), .enemy_score_o(enemy_score_o),
    .game_over_o(game_over_o), .winner_o(winner_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
  task automatic applyStimulus(input logic nf, input logic st, input logic [9:0] bx);
    new_frame_i = nf;
    start_i     = st;
    ball_x_i    = bx;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic serveFrames();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) applyStimulus(1'b0, start_i, 10'd320);
      if (i == 2) checkOutput("serve_run_before_last", 32'(run_o), 32'd0);
      applyStimulus(1'b1, start_i, 10'd320);
    end
    checkOutput("serve_run_after_last", 32'(run_o), 32'd1);
    checkOutput("serve_state_play", 32'(state_o), 32'd2);
  endtask

  initial begin
    // Reset with start held high.
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 10'd320);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_run", 32'(run_o), 32'd0);
    checkOutput("rst_serve", 32'(serve_o), 32'd0);
    checkOutput("rst_scores", {24'd0, player_score_o, enemy_score_o}, 32'd0);
    checkOutput("rst_over", {30'd0, game_over_o, winner_o}, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("held_start_no_edge", 32'(state_o), 32'd0);

    // First real press.
    applyStimulus(1'b0, 1'b0, 10'd320);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("press_state_serve", 32'(state_o), 32'd1);
    checkOutput("press_serve_pulse", 32'(serve_o), 32'd1);
    checkOutput("press_run", 32'(run_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("serve_pulse_one_cycle", 32'(serve_o), 32'd0);
    serveFrames();

    // Pause and resume.
    applyStimulus(1'b0, 1'b0, 10'd320);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("pause_state", 32'(state_o), 32'd4);
    checkOutput("pause_run", 32'(run_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 10'd641);
    checkOutput("pause_scores_held", {24'd0, player_score_o, enemy_score_o}, 32'd0);
    checkOutput("pause_state_held", 32'(state_o), 32'd4);
    applyStimulus(1'b0, 1'b0, 10'd320);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("resume_state", 32'(state_o), 32'd2);
    checkOutput("resume_run", 32'(run_o), 32'd1);
    checkOutput("resume_no_serve", 32'(serve_o), 32'd0);

    // Boundaries are not misses; a miss without a frame strobe is ignored.
    applyStimulus(1'b1, 1'b1, 10'd640);
    checkOutput("edge_640_no_miss", 32'(state_o), 32'd2);
    applyStimulus(1'b1, 1'b1, 10'd10);
    checkOutput("edge_10_no_miss", 32'(state_o), 32'd2);
    applyStimulus(1'b0, 1'b1, 10'd641);
    checkOutput("no_strobe_no_score", 32'(enemy_score_o), 32'd0);

    // Player misses on the right.
    applyStimulus(1'b1, 1'b1, 10'd641);
    checkOutput("right_miss_enemy", 32'(enemy_score_o), 32'd1);
    checkOutput("right_miss_dir", 32'(serve_dir_o), 32'd1);
    checkOutput("right_miss_point", 32'(state_o), 32'd3);
    checkOutput("right_miss_run", 32'(run_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("point_to_serve", 32'(state_o), 32'd1);
    checkOutput("point_serve_pulse", 32'(serve_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd320);
    serveFrames();

    // Enemy misses on the left together with a start press: miss wins.
    applyStimulus(1'b1, 1'b1, 10'd5);
    checkOutput("left_miss_player", 32'(player_score_o), 32'd1);
    checkOutput("left_miss_dir", 32'(serve_dir_o), 32'd0);
    checkOutput("left_miss_not_pause", 32'(state_o), 32'd3);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("left_serve_pulse", 32'(serve_o), 32'd1);
    serveFrames();

    // Second enemy point ends the match.
    applyStimulus(1'b1, 1'b1, 10'd700);
    checkOutput("over_state", 32'(state_o), 32'd5);
    checkOutput("over_flag", 32'(game_over_o), 32'd1);
    checkOutput("over_winner", 32'(winner_o), 32'd1);
    checkOutput("over_run", 32'(run_o), 32'd0);
    checkOutput("over_enemy", 32'(enemy_score_o), 32'd2);
    applyStimulus(1'b1, 1'b0, 10'd5);
    checkOutput("over_scores_frozen", {24'd0, player_score_o, enemy_score_o}, 32'h12);
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("restart_state", 32'(state_o), 32'd1);
    checkOutput("restart_serve", 32'(serve_o), 32'd1);
    checkOutput("restart_scores", {24'd0, player_score_o, enemy_score_o}, 32'd0);
    checkOutput("restart_flags", {29'd0, game_over_o, winner_o, serve_dir_o}, 32'd0);

    // Reset in the middle of a serve.
    applyStimulus(1'b1, 1'b1, 10'd320);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("midserve_rst_state", 32'(state_o), 32'd0);
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 10'd320);
    checkOutput("midserve_rst_no_serve", 32'(serve_o), 32'd0);
    checkOutput("midserve_rst_idle", 32'(state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
